// File: rtl/baccarat_deal_sequencer_if.sv
// Bus between the baccarat round sequencer and the card/score datapath.
// The datapath (or a bench standing in for it) uses master; the sequencer uses slave.
interface baccarat_deal_sequencer_if #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
);
  logic               step;
  logic [SCORE_W-1:0] pscore;
  logic [SCORE_W-1:0] dscore;
  logic [CARD_W-1:0]  pcard3;
  logic               load_pcard1;
  logic               load_pcard2;
  logic               load_pcard3;
  logic               load_dcard1;
  logic               load_dcard2;
  logic               load_dcard3;
  logic [2:0]         cards_dealt;
  logic               round_done;
  logic               player_win_light;
  logic               dealer_win_light;

  modport master (
    output step, pscore, dscore, pcard3,
    input  load_pcard1, load_pcard2, load_pcard3,
    input  load_dcard1, load_dcard2, load_dcard3,
    input  cards_dealt, round_done, player_win_light, dealer_win_light
  );

  modport slave (
    input  step, pscore, dscore, pcard3,
    output load_pcard1, load_pcard2, load_pcard3,
    output load_dcard1, load_dcard2, load_dcard3,
    output cards_dealt, round_done, player_win_light, dealer_win_light
  );
endinterface

// File: rtl/baccarat_deal_sequencer.sv
// Baccarat round controller: four fixed deals, tableau-driven third cards,
// then registered win lights held while the round sits in DONE.
module baccarat_deal_sequencer #(
  parameter int CARD_W  = 4,
  parameter int SCORE_W = 4
) (
  input  logic                     slow_clock,
  input  logic                     reset,
  baccarat_deal_sequencer_if.slave bus
);
  typedef enum logic [3:0] {
    DEAL_P1   = 4'd0,
    DEAL_D1   = 4'd1,
    DEAL_P2   = 4'd2,
    DEAL_D2   = 4'd3,
    EVAL      = 4'd4,
    DEAL_P3   = 4'd5,
    BANK_EVAL = 4'd6,
    DEAL_D3   = 4'd7,
    DONE      = 4'd8
  } state_t;

  state_t      state_q, state_d;
  logic [2:0]  cards_q, cards_d;
  logic        done_q, done_d;
  logic        pwin_q, pwin_d;
  logic        dwin_q, dwin_d;
  logic        adv_s;
  logic        any_load_s;
  logic        bank_draw_s;
  logic [CARD_W-1:0] pcard3_v_s;

  // Banker third-card tableau, keyed on banker score and player third-card value.
  always_comb begin
    pcard3_v_s  = (bus.pcard3 >= CARD_W'(10)) ? {CARD_W{1'b0}} : bus.pcard3;
    bank_draw_s = 1'b0;
    if (bus.dscore <= SCORE_W'(2)) begin
      bank_draw_s = 1'b1;
    end else if (bus.dscore == SCORE_W'(3)) begin
      bank_draw_s = (pcard3_v_s != CARD_W'(8));
    end else if (bus.dscore == SCORE_W'(4)) begin
      bank_draw_s = (pcard3_v_s >= CARD_W'(2)) && (pcard3_v_s <= CARD_W'(7));
    end else if (bus.dscore == SCORE_W'(5)) begin
      bank_draw_s = (pcard3_v_s >= CARD_W'(4)) && (pcard3_v_s <= CARD_W'(7));
    end else if (bus.dscore == SCORE_W'(6)) begin
      bank_draw_s = (pcard3_v_s >= CARD_W'(6)) && (pcard3_v_s <= CARD_W'(7));
    end else begin
      bank_draw_s = 1'b0;
    end
  end

  // Load strobes: combinational, gated by step and suppressed during reset.
  always_comb begin
    adv_s           = bus.step & ~reset;
    bus.load_pcard1 = (state_q == DEAL_P1) & adv_s;
    bus.load_dcard1 = (state_q == DEAL_D1) & adv_s;
    bus.load_pcard2 = (state_q == DEAL_P2) & adv_s;
    bus.load_dcard2 = (state_q == DEAL_D2) & adv_s;
    bus.load_pcard3 = (state_q == DEAL_P3) & adv_s;
    bus.load_dcard3 = (state_q == DEAL_D3) & adv_s;
    any_load_s      = bus.load_pcard1 | bus.load_dcard1 | bus.load_pcard2 |
                      bus.load_dcard2 | bus.load_pcard3 | bus.load_dcard3;
  end

  // Next-state, card count and light computation.
  always_comb begin
    state_d = state_q;
    if (bus.step) begin
      case (state_q)
        DEAL_P1:   state_d = DEAL_D1;
        DEAL_D1:   state_d = DEAL_P2;
        DEAL_P2:   state_d = DEAL_D2;
        DEAL_D2:   state_d = EVAL;
        EVAL: begin
          if ((bus.pscore >= SCORE_W'(8)) || (bus.dscore >= SCORE_W'(8))) begin
            state_d = DONE;
          end else if (bus.pscore <= SCORE_W'(5)) begin
            state_d = DEAL_P3;
          end else if (bus.dscore <= SCORE_W'(5)) begin
            state_d = DEAL_D3;
          end else begin
            state_d = DONE;
          end
        end
        DEAL_P3:   state_d = BANK_EVAL;
        BANK_EVAL: state_d = bank_draw_s ? DEAL_D3 : DONE;
        DEAL_D3:   state_d = DONE;
        DONE:      state_d = DONE;
        default:   state_d = DEAL_P1;
      endcase
    end else begin
      state_d = state_q;
    end

    if (any_load_s && (cards_q < 3'd6)) begin
      cards_d = cards_q + 3'd1;
    end else begin
      cards_d = cards_q;
    end

    // Lights follow the scores on every cycle spent in DONE and are dark elsewhere.
    done_d = (state_d == DONE);
    if (done_d) begin
      pwin_d = (bus.pscore >= bus.dscore);
      dwin_d = (bus.dscore >= bus.pscore);
    end else begin
      pwin_d = 1'b0;
      dwin_d = 1'b0;
    end
  end

  // Round state and registered outputs.
  always_ff @(posedge slow_clock) begin
    if (reset) begin
      state_q <= DEAL_P1;
      cards_q <= 3'd0;
      done_q  <= 1'b0;
      pwin_q  <= 1'b0;
      dwin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cards_q <= cards_d;
      done_q  <= done_d;
      pwin_q  <= pwin_d;
      dwin_q  <= dwin_d;
    end
  end

  assign bus.cards_dealt      = cards_q;
  assign bus.round_done       = done_q;
  assign bus.player_win_light = pwin_q;
  assign bus.dealer_win_light = dwin_q;
endmodule

// File: tb/tb_baccarat_deal_sequencer.sv
// Scoreboarded bench for the baccarat round sequencer: expected load strobes are
// queued as steps are driven and matched by a monitor on the falling clock edge.
module tb_baccarat_deal_sequencer;
  localparam logic [5:0] S_P1 = 6'b000001;
  localparam logic [5:0] S_P2 = 6'b000010;
  localparam logic [5:0] S_P3 = 6'b000100;
  localparam logic [5:0] S_D1 = 6'b001000;
  localparam logic [5:0] S_D2 = 6'b010000;
  localparam logic [5:0] S_D3 = 6'b100000;

  logic clk;
  logic reset;
  int   checks;
  int   errors;
  logic [5:0] exp_q[$];
  logic [5:0] strobes;

  baccarat_deal_sequencer_if #(.CARD_W(4), .SCORE_W(4)) bus ();

  baccarat_deal_sequencer #(.CARD_W(4), .SCORE_W(4)) dut (
    .slow_clock (clk),
    .reset      (reset),
    .bus        (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign strobes = {bus.load_dcard3, bus.load_dcard2, bus.load_dcard1,
                    bus.load_pcard3, bus.load_pcard2, bus.load_pcard1};

  // Strobe monitor: every observed strobe must match the head of the scoreboard.
  always @(negedge clk) begin
    logic [5:0] exp;
    if (strobes !== 6'd0) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_strobe: got %b, required none", strobes);
      end else begin
        exp = exp_q.pop_front();
        if (strobes !== exp) begin
          errors++;
          $display("FAIL strobe_order: got %b, required %b", strobes, exp);
        end
      end
    end
  end

  function automatic bit bank_draws(input int d, input int rank);
    int v;
    v = (rank >= 10) ? 0 : rank;
    case (d)
      0, 1, 2: return 1'b1;
      3:       return v != 8;
      4:       return v >= 2 && v <= 7;
      5:       return v >= 4 && v <= 7;
      6:       return v == 6 || v == 7;
      default: return 1'b0;
    endcase
  endfunction

  task automatic step_once();
    @(posedge clk);
    #1 bus.step = 1'b1;
    @(posedge clk);
    #1 bus.step = 1'b0;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic deal_four();
    exp_q.push_back(S_P1); step_once();
    exp_q.push_back(S_D1); step_once();
    exp_q.push_back(S_P2); step_once();
    exp_q.push_back(S_D2); step_once();
  endtask

  task automatic chk(input string name, input int got, input int want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, got, want);
    end
  endtask

  task automatic chk_out(input string tag, input int cards, input int done, input int pl, input int dl);
    chk({tag, "_cards"}, int'(bus.cards_dealt), cards);
    chk({tag, "_done"}, int'(bus.round_done), done);
    chk({tag, "_player"}, int'(bus.player_win_light), pl);
    chk({tag, "_dealer"}, int'(bus.dealer_win_light), dl);
    chk({tag, "_queue"}, exp_q.size(), 0);
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 reset = 1'b1; bus.step = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0; bus.step = 1'b0;
    chk_out("reset", 0, 0, 0, 0);
  endtask

  task automatic test_first_four();
    do_reset();
    deal_four();
    chk_out("four", 4, 0, 0, 0);
  endtask

  task automatic test_natural();
    do_reset();
    deal_four();
    bus.pscore = 4'd8; bus.dscore = 4'd3;
    step_once();
    chk_out("natural", 4, 1, 1, 0);
    step_once();
    step_once();
    chk_out("natural_hold", 4, 1, 1, 0);
  endtask

  task automatic test_three_cards();
    do_reset();
    deal_four();
    bus.pscore = 4'd4; bus.dscore = 4'd6;
    step_once();
    exp_q.push_back(S_P3); step_once();
    bus.pcard3 = 4'd7;
    step_once();
    bus.pscore = 4'd9; bus.dscore = 4'd5;
    exp_q.push_back(S_D3); step_once();
    chk_out("six_cards", 6, 1, 1, 0);
  endtask

  task automatic test_bank_stand();
    do_reset();
    deal_four();
    bus.pscore = 4'd4; bus.dscore = 4'd3;
    step_once();
    exp_q.push_back(S_P3); step_once();
    bus.pcard3 = 4'd8;
    bus.pscore = 4'd7; bus.dscore = 4'd7;
    step_once();
    chk_out("bank_stand_tie", 5, 1, 1, 1);
    do_reset();
    deal_four();
    bus.pscore = 4'd4; bus.dscore = 4'd3;
    step_once();
    exp_q.push_back(S_P3); step_once();
    bus.pcard3 = 4'd12;
    step_once();
    chk("queen_not_done", int'(bus.round_done), 0);
    bus.pscore = 4'd5; bus.dscore = 4'd8;
    exp_q.push_back(S_D3); step_once();
    chk_out("queen_draw", 6, 1, 0, 1);
  endtask

  task automatic test_player_stands();
    do_reset();
    deal_four();
    bus.pscore = 4'd6; bus.dscore = 4'd5;
    step_once();
    chk("stand_not_done", int'(bus.round_done), 0);
    bus.dscore = 4'd2;
    exp_q.push_back(S_D3); step_once();
    chk_out("player_stands", 5, 1, 1, 0);
  endtask

  task automatic test_bank_table();
    int d_tab[12] = '{4, 4, 5, 5, 6, 6, 6, 7, 2, 3, 4, 5};
    int c_tab[12] = '{1, 2, 3, 4, 5, 6, 8, 6, 8, 13, 11, 8};
    for (int i = 0; i < 12; i++) begin
      bit draw;
      draw = bank_draws(d_tab[i], c_tab[i]);
      do_reset();
      deal_four();
      bus.pscore = 4'd3; bus.dscore = 4'(d_tab[i]);
      step_once();
      exp_q.push_back(S_P3); step_once();
      bus.pcard3 = 4'(c_tab[i]);
      step_once();
      chk($sformatf("table%0d_bank_done", i), int'(bus.round_done), draw ? 0 : 1);
      if (draw) begin
        exp_q.push_back(S_D3);
        step_once();
      end
      chk($sformatf("table%0d_cards", i), int'(bus.cards_dealt), draw ? 6 : 5);
      chk($sformatf("table%0d_queue", i), exp_q.size(), 0);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    deal_four();
    bus.pscore = 4'd4; bus.dscore = 4'd4;
    step_once();
    #1 reset = 1'b1; bus.step = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0; bus.step = 1'b0;
    chk_out("mid_reset", 0, 0, 0, 0);
    exp_q.push_back(S_P1); step_once();
    repeat (10) @(posedge clk);
    #1 chk_out("hold_d1", 1, 0, 0, 0);
    exp_q.push_back(S_D1); step_once();
    chk_out("after_hold", 2, 0, 0, 0);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    bus.step = 1'b0;
    bus.pscore = 4'd0;
    bus.dscore = 4'd0;
    bus.pcard3 = 4'd1;
    test_reset();
    test_first_four();
    test_natural();
    test_three_cards();
    test_bank_stand();
    test_player_stands();
    test_bank_table();
    test_mid_reset();
    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
